// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serializer-side TX arbiter.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_e;

  localparam logic [7:0] HDR_TAG_DEF = 8'h28;

  // Channel-id width; a single channel still needs one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Header byte = tag in the upper bits, channel id in the low chw bits.
  function automatic logic [7:0] hdr_compose(input logic [7:0] tag,
                                             input logic [2:0] id,
                                             input int unsigned chw);
    return 8'((tag << chw) | {5'd0, id});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
module rr_arbiter
  import serdes_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   id
);

  logic            found;
  logic [CH_W-1:0] idx;

  // NUM_CH is a power of two, so CH_W-bit addition wraps modulo NUM_CH.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the PISO byte interface;
// each packet is prefixed with a header byte carrying the channel id.
module serdes_tx_arbiter
  import serdes_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter logic [7:0]  HDR_TAG = HDR_TAG_DEF,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                       pclk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH-1:0]          req_valid_i,
  input  logic [NUM_CH*DATA_W-1:0]   req_data_i,
  input  logic [NUM_CH-1:0]          req_last_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  output logic [DATA_W-1:0]          tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [NUM_CH-1:0]          grant_o,
  output logic                       busy_o,
  output logic                       len_err_o
);

  localparam int unsigned CH_W  = ch_w(NUM_CH);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_ERR_AT = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT    = LEN_W'(MAX_LEN + 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     id_q, id_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [NUM_CH-1:0]   grant_d;
  logic [DATA_W-1:0]   tx_data_d;
  logic                tx_valid_d;
  logic                len_err_d;
  logic                busy_d;

  logic                out_free;
  logic                accept;
  logic [NUM_CH-1:0]   arb_gnt;
  logic [CH_W-1:0]     arb_id;
  logic [DATA_W-1:0]   cur_data;
  logic [DATA_W-1:0]   hdr_byte;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  assign out_free = !tx_valid_o || tx_ready_i;
  assign cur_data = req_data_i[32'(id_q) * DATA_W +: DATA_W];
  assign hdr_byte = DATA_W'(hdr_compose(HDR_TAG, 3'(id_q), CH_W));
  assign accept   = (state_q == ST_DATA) && req_valid_i[id_q] && out_free;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    grant_d     = grant_o;
    tx_data_d   = tx_data_o;
    tx_valid_d  = tx_valid_o && !tx_ready_i;
    len_err_d   = 1'b0;
    req_ready_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_d = arb_gnt;
          id_d    = arb_id;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_free) begin
          tx_data_d  = hdr_byte;
          tx_valid_d = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        req_ready_o[id_q] = out_free;
        if (accept) begin
          tx_data_d  = cur_data;
          tx_valid_d = 1'b1;
          // Saturating count keeps the overlength pulse to one per packet.
          if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
          if (len_q == LEN_ERR_AT) len_err_d = 1'b1;
          if (req_last_i[id_q]) begin
            ptr_d   = id_q + CH_W'(1);
            grant_d = '0;
            len_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || tx_valid_d;
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      grant_o    <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      len_err_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      grant_o    <= grant_d;
      tx_data_o  <= tx_data_d;
      tx_valid_o <= tx_valid_d;
      len_err_o  <= len_err_d;
      busy_o     <= busy_d;
    end
  end

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Bench for serdes_tx_arbiter: cycle vectors, directed corner sequences,
// and randomized traffic against a round-robin packet-order model.
module tb_serdes_tx_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     pclk_i;
  logic                     rst_i;
  logic [NUM_CH-1:0]        req_valid_i;
  logic [NUM_CH*DATA_W-1:0] req_data_i;
  logic [NUM_CH-1:0]        req_last_i;
  logic [NUM_CH-1:0]        req_ready_o;
  logic [DATA_W-1:0]        tx_data_o;
  logic                     tx_valid_o;
  logic                     tx_ready_i;
  logic [NUM_CH-1:0]        grant_o;
  logic                     busy_o;
  logic                     len_err_o;

  serdes_tx_arbiter dut (
    .pclk_i      (pclk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .len_err_o   (len_err_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  lst;
    logic        e_tv;
    logic [7:0]  e_td;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rr;
    logic        e_busy;
  } vec_t;

  vec_t tv[24];

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Per-channel byte queues: {first, last, data}.
  logic [9:0]        chq [NUM_CH][$];
  logic [7:0]        pb  [NUM_CH][$];
  int                lens[NUM_CH][$];
  logic [NUM_CH-1:0] gap;
  logic [7:0]        obs[$];
  int                lerr_cnt;
  logic [7:0]        lerr_byte;
  bit                rnd;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic etv, input logic [7:0] etd,
                              input logic [3:0] eg, input logic [3:0] err, input logic eb);
    vec_t x;
    x.rst = r; x.vld = v; x.dat = d; x.lst = l;
    x.e_tv = etv; x.e_td = etd; x.e_gnt = eg; x.e_rr = err; x.e_busy = eb;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive();
    for (int k = 0; k < NUM_CH; k++) begin
      if (rnd) gap[k] = (chq[k].size() > 0) && !chq[k][0][9] && ($urandom_range(3) == 0);
      req_valid_i[k] = (chq[k].size() > 0) && !gap[k];
      req_data_i[k*DATA_W +: DATA_W] = (chq[k].size() > 0) ? chq[k][0][7:0] : 8'h00;
      req_last_i[k] = (chq[k].size() > 0) && chq[k][0][8];
    end
    if (rnd) tx_ready_i = ($urandom_range(2) != 0);
  endtask

  // One clock: observe at the falling edge, advance sources after the rising edge.
  task automatic step();
    logic [NUM_CH-1:0] acc;
    @(negedge pclk_i);
    if (tx_valid_o && tx_ready_i) obs.push_back(tx_data_o);
    if (len_err_o) begin
      lerr_cnt++;
      lerr_byte = tx_data_o;
    end
    acc = req_valid_i & req_ready_o;
    @(posedge pclk_i);
    #1;
    for (int k = 0; k < NUM_CH; k++) if (acc[k]) void'(chq[k].pop_front());
    drive();
  endtask

  task automatic add_pkt(input int k, input int len, input logic [7:0] base, input bit rand_en);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = rand_en ? 8'($urandom) : 8'(base + 8'(i));
      chq[k].push_back({(i == 0), (i == len - 1), b});
      pb[k].push_back(b);
    end
    lens[k].push_back(len);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      chq[k].delete();
      pb[k].delete();
      lens[k].delete();
    end
    gap = '0;
    rnd = 1'b0;
    tx_ready_i = 1'b1;
    drive();
    @(posedge pclk_i);
    #1;
    rst_i = 1'b0;
    obs.delete();
    lerr_cnt = 0;
    lerr_byte = 8'h00;
  endtask

  task automatic cmp_stream(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, 64'(obs.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_b%0d", name, i), (i < obs.size()) ? 64'(obs[i]) : 64'hFFFF, 64'(exp[i]));
  endtask

  initial begin
    logic [7:0] e[$];
    int gapcnt, n, p, k, exp_lerr;
    int pk[NUM_CH];
    int off[NUM_CH];
    bit done;

    // Cycle vectors: single-channel packet, reset, 4-way contention, pointer wrap.
    tv[0]  = mk(0, 4'h4, 32'h00110000, 4'h0, 0, 8'h00, 4'h0, 4'h0, 0);
    tv[1]  = mk(0, 4'h4, 32'h00110000, 4'h0, 0, 8'h00, 4'h4, 4'h0, 1);
    tv[2]  = mk(0, 4'h4, 32'h00110000, 4'h0, 1, 8'hA2, 4'h4, 4'h4, 1);
    tv[3]  = mk(0, 4'h4, 32'h00220000, 4'h0, 1, 8'h11, 4'h4, 4'h4, 1);
    tv[4]  = mk(0, 4'h4, 32'h00330000, 4'h4, 1, 8'h22, 4'h4, 4'h4, 1);
    tv[5]  = mk(0, 4'h0, 32'h00000000, 4'h0, 1, 8'h33, 4'h0, 4'h0, 1);
    tv[6]  = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 8'h33, 4'h0, 4'h0, 0);
    tv[7]  = mk(1, 4'h0, 32'h00000000, 4'h0, 0, 8'h33, 4'h0, 4'h0, 0);
    tv[8]  = mk(0, 4'hF, 32'h13121110, 4'hF, 0, 8'h00, 4'h0, 4'h0, 0);
    tv[9]  = mk(0, 4'hF, 32'h13121110, 4'hF, 0, 8'h00, 4'h1, 4'h0, 1);
    tv[10] = mk(0, 4'hF, 32'h13121110, 4'hF, 1, 8'hA0, 4'h1, 4'h1, 1);
    tv[11] = mk(0, 4'hE, 32'h13121110, 4'hF, 1, 8'h10, 4'h0, 4'h0, 1);
    tv[12] = mk(0, 4'hE, 32'h13121110, 4'hF, 0, 8'h10, 4'h2, 4'h0, 1);
    tv[13] = mk(0, 4'hE, 32'h13121110, 4'hF, 1, 8'hA1, 4'h2, 4'h2, 1);
    tv[14] = mk(0, 4'hC, 32'h13121110, 4'hF, 1, 8'h11, 4'h0, 4'h0, 1);
    tv[15] = mk(0, 4'hC, 32'h13121110, 4'hF, 0, 8'h11, 4'h4, 4'h0, 1);
    tv[16] = mk(0, 4'hC, 32'h13121110, 4'hF, 1, 8'hA2, 4'h4, 4'h4, 1);
    tv[17] = mk(0, 4'h8, 32'h13121110, 4'hF, 1, 8'h12, 4'h0, 4'h0, 1);
    tv[18] = mk(0, 4'h8, 32'h13121110, 4'hF, 0, 8'h12, 4'h8, 4'h0, 1);
    tv[19] = mk(0, 4'h8, 32'h13121110, 4'hF, 1, 8'hA3, 4'h8, 4'h8, 1);
    tv[20] = mk(0, 4'h0, 32'h13121110, 4'hF, 1, 8'h13, 4'h0, 4'h0, 1);
    tv[21] = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 8'h13, 4'h0, 4'h0, 0);
    tv[22] = mk(0, 4'h3, 32'h00002120, 4'h3, 0, 8'h13, 4'h0, 4'h0, 0);
    tv[23] = mk(0, 4'h3, 32'h00002120, 4'h3, 0, 8'h13, 4'h1, 4'h0, 1);

    rst_i = 1'b1;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    tx_ready_i = 1'b1;
    gap = '0;
    rnd = 1'b0;
    repeat (2) @(posedge pclk_i);
    #1;
    rst_i = 1'b0;
    check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("rst_tx_data", 64'(tx_data_o), 64'd0);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_len_err", 64'(len_err_o), 64'd0);

    for (int i = 0; i < 24; i++) begin
      rst_i = tv[i].rst;
      req_valid_i = tv[i].vld;
      req_data_i = tv[i].dat;
      req_last_i = tv[i].lst;
      tx_ready_i = 1'b1;
      @(negedge pclk_i);
      check($sformatf("vec%0d{tv,td,gnt,rdy,busy,lerr}", i),
            64'({tx_valid_o, tx_data_o, grant_o, req_ready_o, busy_o, len_err_o}),
            64'({tv[i].e_tv, tv[i].e_td, tv[i].e_gnt, tv[i].e_rr, tv[i].e_busy, 1'b0}));
      @(posedge pclk_i);
      #1;
    end

    // Backpressure: PISO stalls for 5 cycles while byte 0x53 is on the lane.
    do_reset();
    add_pkt(0, 5, 8'h51, 0);
    drive();
    for (int c = 0; c < 20; c++) begin
      tx_ready_i = !(c >= 5 && c < 10);
      if (!tx_ready_i) begin
        #1;
        check($sformatf("bp_hold_c%0d{tv,td,rdy}", c),
              64'({tx_valid_o, tx_data_o, req_ready_o}), 64'({1'b1, 8'h53, 4'h0}));
      end
      step();
    end
    e = {8'hA0, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    cmp_stream("bp", e);

    // Gap: granted ch1 pauses mid-packet while ch3 waits.
    do_reset();
    add_pkt(1, 4, 8'h61, 0);
    add_pkt(3, 2, 8'h71, 0);
    gapcnt = 0;
    for (int c = 0; c < 40; c++) begin
      gap[1] = (chq[1].size() == 2) && (gapcnt < 3);
      drive();
      if (gap[1]) begin
        gapcnt++;
        #1;
        check($sformatf("gap_grant%0d", gapcnt), 64'(grant_o), 64'h2);
      end
      step();
    end
    check("gap_cycles", 64'(gapcnt), 64'd3);
    e = {8'hA1, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA3, 8'h71, 8'h72};
    cmp_stream("gap", e);

    // Overlength: 18-byte packet on ch0.
    do_reset();
    add_pkt(0, 18, 8'h80, 0);
    drive();
    repeat (30) step();
    check("ovl_pulses", 64'(lerr_cnt), 64'd1);
    check("ovl_on_byte17", 64'(lerr_byte), 64'h90);
    e = {8'hA0};
    for (int i = 0; i < 18; i++) e.push_back(8'(8'h80 + 8'(i)));
    cmp_stream("ovl", e);

    // Reset in the middle of a ch2 packet, then a fresh ch3 request.
    do_reset();
    add_pkt(0, 1, 8'h30, 0);
    add_pkt(2, 5, 8'h40, 0);
    drive();
    n = 0;
    while (chq[2].size() != 3 && n < 40) begin
      step();
      n++;
    end
    check("mid_rst_reached", 64'(chq[2].size()), 64'd3);
    rst_i = 1'b1;
    chq[2].delete();
    drive();
    @(posedge pclk_i);
    #1;
    rst_i = 1'b0;
    check("mid_rst_outs{tv,td,gnt,rdy,busy,lerr}",
          64'({tx_valid_o, tx_data_o, grant_o, req_ready_o, busy_o, len_err_o}), 64'd0);
    obs.delete();
    add_pkt(3, 2, 8'h50, 0);
    drive();
    repeat (12) step();
    e = {8'hA3, 8'h50, 8'h51};
    cmp_stream("post_rst", e);

    // Randomized traffic: per-channel packet queues, random stalls and gaps.
    do_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 3; j++) add_pkt(c, int'($urandom_range(20, 1)), 8'h00, 1);
    e.delete();
    p = 0;
    exp_lerr = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      pk[c] = 0;
      off[c] = 0;
    end
    forever begin
      k = -1;
      for (int i = 0; i < NUM_CH; i++)
        if (k < 0 && pk[(p + i) % NUM_CH] < lens[(p + i) % NUM_CH].size()) k = (p + i) % NUM_CH;
      if (k < 0) break;
      e.push_back(8'(8'hA0 + 8'(k)));
      for (int j = 0; j < lens[k][pk[k]]; j++) e.push_back(pb[k][off[k] + j]);
      if (lens[k][pk[k]] > 16) exp_lerr++;
      off[k] += lens[k][pk[k]];
      pk[k]++;
      p = (k + 1) % NUM_CH;
    end
    rnd = 1'b1;
    drive();
    n = 0;
    done = 1'b0;
    while (!done && n < 6000) begin
      step();
      n++;
      done = (chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size() == 0)
             && (obs.size() >= e.size());
    end
    check("rand_completed", 64'(done), 64'd1);
    rnd = 1'b0;
    tx_ready_i = 1'b1;
    gap = '0;
    drive();
    repeat (5) step();
    cmp_stream("rand", e);
    check("rand_len_err", 64'(lerr_cnt), 64'(exp_lerr));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serdes_tx_arbiter.md
Name: serdes_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one parallel TX lane, the 8-bit valid/ready input of the PISO serializer, among NUM_CH byte-stream requesters.
- Each granted packet is prefixed with a header byte carrying the channel ID, so the far-end SIPO side can demultiplex.
- Sits in the pclk_i domain, directly in front of the PISO stage.

Parameters:
- NUM_CH, 4, number of requester channels (power of 2, 2..8).
- DATA_W, 8, byte width of every data path.
- HDR_TAG, 6'h28, upper DATA_W-CH_W bits of the header byte (CH_W = clog2(NUM_CH)).
- MAX_LEN, 16, data bytes per packet above which len_err_o pulses.

Ports:
- pclk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_CH  per-channel byte valid.
- req_data_i  in  NUM_CH*DATA_W  per-channel byte; channel k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  in  NUM_CH  marks the final byte of the packet.
- req_ready_o  out  NUM_CH  per-channel accept.
- tx_data_o  out  DATA_W  byte to the PISO.
- tx_valid_o  out  1  byte valid to the PISO.
- tx_ready_i  in  1  PISO ready.
- grant_o  out  NUM_CH  one-hot current owner; all zeros in IDLE.
- busy_o  out  1  high when state != IDLE or tx_valid_o = 1.
- len_err_o  out  1  one-cycle pulse on packet overlength.

Behaviour:
- Reset (sync, rst_i=1 at an edge) values: state=IDLE, tx_valid_o=0, tx_data_o=0, grant_o=0, req_ready_o=0, len_err_o=0, busy_o=0, rr pointer=0, length counter=0.
- Reset mid-packet abandons the packet. No header or data is replayed.
- Output register: tx_data_o/tx_valid_o are flops.
  - out_free = !tx_valid_o || tx_ready_i.
  - On tx_valid_o & tx_ready_i with nothing new loaded, tx_valid_o clears next cycle.
  - tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0.
- State IDLE:
  - If any req_valid_i is set, the round-robin winner is the first set bit searching from pointer, pointer+1, and so on (mod NUM_CH).
  - grant_o is registered with the winner and the state moves to HDR.
  - With no requests, stay in IDLE.
- State HDR:
  - When out_free, load tx_data_o = {HDR_TAG, winner_id}, set tx_valid_o=1, go to DATA.
  - Default header for channel k is 8'hA0+k.
- State DATA:
  - req_ready_o[g] = out_free for the granted channel g; all other req_ready_o bits are 0. This is combinational from tx_ready_i.
  - On req_valid_i[g] & req_ready_o[g], load req_data_i[g] into tx_data_o and increment the length counter.
  - If req_last_i[g] is also set: pointer <= g+1 (mod NUM_CH), grant_o <= 0, counter <= 0, next state IDLE.
  - If the granted channel drops valid mid-packet, the grant is held and the arbiter waits; no timeout.
- Latency, with tx_ready_i=1 throughout:
  - req_valid at cycle 0 gives grant at cycle 1 and the header on tx at cycle 2.
  - The first data byte is accepted at cycle 2 and appears on tx at cycle 3.
  - Back-to-back packets cost 2 non-data tx cycles between them: one bubble plus the header.
- Simultaneous requests: only the winner is granted. A channel that becomes valid during another channel's packet waits for the next IDLE arbitration.
- A zero-length packet cannot exist: the first data byte may carry last, giving header + 1 byte.
- len_err_o:
  - Pulses for one cycle when data byte number MAX_LEN+1 of the packet is accepted.
  - The packet continues unmodified.
  - The counter saturates, so there is at most one pulse per packet.
- Other channels' req_data_i are ignored; data is never merged across channels.

Decomposition:
- Package serdes_pkg holds:
  - the state encoding (IDLE, HDR, DATA);
  - the CH_W derivation function;
  - HDR_TAG default;
  - the header-compose helper.
- Sub-module rr_arbiter (inputs: req vector, pointer; output: one-hot grant plus binary id) is combinational and reused by future RX-side schedulers.

Test Plan:
- Single channel: ch2 sends 3 bytes 11,22,33 (last on 33), tx_ready_i=1 -> tx sequence A2,11,22,33; tx_valid_o first high at cycle 2; grant_o=0100 during the packet, then 0000.
- Contention: ch0..ch3 all valid with 1-byte packets (data 0x10+k) from reset -> order A0,10,A1,11,A2,12,A3,13; pointer wraps back to 0.
- Backpressure: tx_ready_i low for 5 cycles mid-packet -> tx_data_o stable, req_ready_o[g]=0, no bytes lost or duplicated.
- Gap: granted ch1 drops valid for 3 cycles mid-packet while ch3 is valid -> grant stays 0010, and ch3 is served only after ch1's last byte.
- Overlength: ch0 sends 18 bytes -> len_err_o pulses exactly once, on acceptance of byte 17; all 18 bytes are transmitted.
- Reset mid-packet: rst_i=1 for 1 cycle after 2 bytes -> next cycle all outputs are 0; a subsequent ch3 request is granted with header A3 (pointer = 0 search).
